// File: rtl/vga_bar_checker_if.sv
// Pixel stream bundle for the colour-bar checker.
// RGB plus data enable and vertical sync.
interface vga_bar_checker_if;
  logic       de;
  logic       vsync;
  logic [7:0] R;
  logic [7:0] G;
  logic [7:0] B;

  modport master (output de, vsync, R, G, B);
  modport slave  (input  de, vsync, R, G, B);
endinterface

// File: rtl/vga_bar_checker.sv
// Receive-side checker for the 8-band horizontal colour-bar pattern.
// Rebuilds coordinates from DE/VSYNC, counts pixel errors, measures geometry.
module vga_bar_checker #(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720,
  parameter int BAND_H   = 90
) (
  input  logic                clk,
  input  logic                rst,
  vga_bar_checker_if.slave    vid,
  output logic                frame_done_o,
  output logic                frame_ok_o,
  output logic [15:0]         err_cnt_o,
  output logic [10:0]         meas_h_o,
  output logic [10:0]         meas_v_o,
  output logic [15:0]         frame_cnt_o,
  output logic                locked_o
);

  localparam logic [10:0] H_W    = 11'(H_ACTIVE);
  localparam logic [10:0] V_W    = 11'(V_ACTIVE);
  localparam logic [10:0] BL_MAX = 11'(BAND_H - 1);
  localparam logic [10:0] SAT11  = 11'h7FF;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t      state_q;
  logic        de_q, vs_q;
  logic [10:0] col_q, row_q, len_q, bline_q;
  logic [2:0]  band_q;
  logic        geom_q;
  logic        mism_q;
  logic [15:0] err_q;
  logic        close_q;
  logic [10:0] pend_row_q, pend_len_q;
  logic        pend_geom_q;

  logic        vs_rise, de_fall;
  logic [23:0] band_rgb, px_exp, pix;
  logic [10:0] row_d, len_d;
  logic        geom_d;

  assign vs_rise = vid.vsync & ~vs_q;
  assign de_fall = ~vid.de & de_q;
  assign pix     = {vid.R, vid.G, vid.B};

  always_comb begin
    band_rgb = 24'hFFFFFF;
    case (band_q)
      3'd0: band_rgb = 24'hFF0000;
      3'd1: band_rgb = 24'hFF8000;
      3'd2: band_rgb = 24'hFFFF00;
      3'd3: band_rgb = 24'h00FF00;
      3'd4: band_rgb = 24'h0000FF;
      3'd5: band_rgb = 24'h800080;
      3'd6: band_rgb = 24'h000000;
      3'd7: band_rgb = 24'hFFFFFF;
      default: band_rgb = 24'hFFFFFF;
    endcase
    px_exp = (col_q >= H_W) ? 24'h000000 : band_rgb;
  end

  // Line-end effects folded in so a close coinciding with de_fall sees them
  always_comb begin
    row_d  = row_q;
    len_d  = len_q;
    geom_d = geom_q;
    if (de_fall) begin
      len_d  = col_q;
      row_d  = (row_q == SAT11) ? row_q : row_q + 11'd1;
      geom_d = geom_q | (col_q != H_W);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      de_q         <= 1'b0;
      vs_q         <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
      len_q        <= '0;
      bline_q      <= '0;
      band_q       <= '0;
      geom_q       <= 1'b0;
      mism_q       <= 1'b0;
      err_q        <= '0;
      close_q      <= 1'b0;
      pend_row_q   <= '0;
      pend_len_q   <= '0;
      pend_geom_q  <= 1'b0;
      frame_done_o <= 1'b0;
      frame_ok_o   <= 1'b0;
      err_cnt_o    <= '0;
      meas_h_o     <= '0;
      meas_v_o     <= '0;
      frame_cnt_o  <= '0;
      locked_o     <= 1'b0;
    end else begin
      de_q         <= vid.de;
      vs_q         <= vid.vsync;
      frame_done_o <= 1'b0;
      close_q      <= 1'b0;
      mism_q       <= (state_q == ACTIVE) && vid.de && !vs_rise &&
                      (pix != px_exp);

      if (close_q) begin
        err_q        <= '0;
        frame_done_o <= 1'b1;
        err_cnt_o    <= err_q;
        meas_v_o     <= pend_row_q;
        meas_h_o     <= pend_len_q;
        frame_ok_o   <= (err_q == 16'h0) && !pend_geom_q;
        frame_cnt_o  <= frame_cnt_o + 16'd1;
        locked_o     <= !pend_geom_q;
      end else if (mism_q && err_q != 16'hFFFF) begin
        err_q <= err_q + 16'd1;
      end

      if (vs_rise) begin
        col_q   <= '0;
        row_q   <= '0;
        len_q   <= '0;
        bline_q <= '0;
        band_q  <= '0;
        geom_q  <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (vs_rise) state_q <= ACTIVE;
        end
        ACTIVE: begin
          if (vs_rise) begin
            close_q     <= 1'b1;
            pend_row_q  <= row_d;
            pend_len_q  <= len_d;
            pend_geom_q <= geom_d | (row_d != V_W) | vid.de;
          end else begin
            if (vid.de && col_q != SAT11) col_q <= col_q + 11'd1;
            if (de_fall) begin
              col_q  <= '0;
              row_q  <= row_d;
              len_q  <= len_d;
              geom_q <= geom_d;
              if (bline_q == BL_MAX) begin
                bline_q <= '0;
                if (band_q != 3'd7) band_q <= band_q + 3'd1;
              end else begin
                bline_q <= bline_q + 11'd1;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_bar_checker.sv
// Directed bench for vga_bar_checker using a reduced 16x24 frame, 3-line bands.
// Expected colours come from a divide-based model of the bar pattern.
module tb_vga_bar_checker;

  localparam int H  = 16;
  localparam int V  = 24;
  localparam int BH = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_done, frame_ok, locked;
  logic [15:0] err_cnt, frame_cnt;
  logic [10:0] meas_h, meas_v;

  int checks = 0;
  int errors = 0;

  vga_bar_checker_if vif ();

  vga_bar_checker #(.H_ACTIVE(H), .V_ACTIVE(V), .BAND_H(BH)) dut (
    .clk          (clk),
    .rst          (rst),
    .vid          (vif),
    .frame_done_o (frame_done),
    .frame_ok_o   (frame_ok),
    .err_cnt_o    (err_cnt),
    .meas_h_o     (meas_h),
    .meas_v_o     (meas_v),
    .frame_cnt_o  (frame_cnt),
    .locked_o     (locked)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] exp_rgb(input int r, input int c);
    int b;
    if (c >= H) return 24'h000000;
    b = r / BH;
    if (b > 7) b = 7;
    case (b)
      0: return 24'hFF0000;
      1: return 24'hFF8000;
      2: return 24'hFFFF00;
      3: return 24'h00FF00;
      4: return 24'h0000FF;
      5: return 24'h800080;
      6: return 24'h000000;
      default: return 24'hFFFFFF;
    endcase
  endfunction

  task automatic send_lines(input int lines, input int sl, input int slen,
                            input int br, input int bc,
                            input logic cst, input logic [23:0] crgb);
    logic [23:0] px;
    for (int r = 0; r < lines; r++) begin
      int n;
      n = (r == sl) ? slen : H;
      for (int c = 0; c < n; c++) begin
        @(posedge clk); #1;
        if (cst) px = crgb;
        else if (r == br && c == bc) px = 24'h000000;
        else px = exp_rgb(r, c);
        vif.de = 1'b1;
        {vif.R, vif.G, vif.B} = px;
      end
      for (int k = 0; k < 4; k++) begin
        @(posedge clk); #1;
        vif.de = 1'b0;
        {vif.R, vif.G, vif.B} = 24'h0;
      end
    end
  endtask

  // Raise vsync for two cycles; report frame_done pulses and their position
  task automatic close_frame(output int ndone, output int at);
    ndone = 0;
    at    = -1;
    @(posedge clk); #1;
    vif.vsync = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      if (i == 2) vif.vsync = 1'b0;
      if (frame_done) begin
        ndone++;
        at = i;
      end
    end
  endtask

  task automatic chk_done(input string nm, input int nd, input int at);
    checks++;
    if (nd !== 1 || at !== 2) begin
      errors++;
      $display("FAIL %s frame_done: pulses=%0d at=%0d, need 1 at 2", nm, nd, at);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    vif.de = 1'b0;
    vif.vsync = 1'b0;
    {vif.R, vif.G, vif.B} = 24'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({frame_done, frame_ok, locked} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b need 000", {frame_done, frame_ok, locked});
    end
    checks++;
    if ({err_cnt, frame_cnt} !== 32'h0) begin
      errors++;
      $display("FAIL reset_counts: err=%0d cnt=%0d need 0", err_cnt, frame_cnt);
    end
    checks++;
    if ({meas_h, meas_v} !== 22'h0) begin
      errors++;
      $display("FAIL reset_meas: h=%0d v=%0d need 0", meas_h, meas_v);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_two_frames;
    int nd, at;
    close_frame(nd, at);
    checks++;
    if (nd !== 0) begin
      errors++;
      $display("FAIL first_vs_no_done: pulses=%0d need 0", nd);
    end
    send_lines(V, -1, 0, -1, -1, 1'b0, 24'h0);
    close_frame(nd, at);
    chk_done("good", nd, at);
    checks++;
    if (frame_ok !== 1'b1 || err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL good_ok: ok=%b err=%0d need 1/0", frame_ok, err_cnt);
    end
    checks++;
    if (meas_h !== 11'd16 || meas_v !== 11'd24) begin
      errors++;
      $display("FAIL good_meas: h=%0d v=%0d need 16/24", meas_h, meas_v);
    end
    checks++;
    if (frame_cnt !== 16'd1 || locked !== 1'b1) begin
      errors++;
      $display("FAIL good_cnt_lock: cnt=%0d lock=%b need 1/1", frame_cnt, locked);
    end
  endtask

  task automatic test_pixel_error;
    int nd, at;
    send_lines(V, -1, 0, 10, 5, 1'b0, 24'h0);
    close_frame(nd, at);
    chk_done("pixerr", nd, at);
    checks++;
    if (err_cnt !== 16'd1 || frame_ok !== 1'b0) begin
      errors++;
      $display("FAIL pixerr: err=%0d ok=%b need 1/0", err_cnt, frame_ok);
    end
    checks++;
    if (locked !== 1'b1 || frame_cnt !== 16'd2) begin
      errors++;
      $display("FAIL pixerr_lock: lock=%b cnt=%0d need 1/2", locked, frame_cnt);
    end
  endtask

  task automatic test_short_line;
    int nd, at;
    send_lines(V, 7, H - 1, -1, -1, 1'b0, 24'h0);
    close_frame(nd, at);
    chk_done("short", nd, at);
    checks++;
    if (frame_ok !== 1'b0 || locked !== 1'b0 || err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL short: ok=%b lock=%b err=%0d need 0/0/0",
               frame_ok, locked, err_cnt);
    end
    send_lines(V, -1, 0, -1, -1, 1'b0, 24'h0);
    close_frame(nd, at);
    chk_done("relock", nd, at);
    checks++;
    if (locked !== 1'b1 || frame_ok !== 1'b1 || frame_cnt !== 16'd4) begin
      errors++;
      $display("FAIL relock: lock=%b ok=%b cnt=%0d need 1/1/4",
               locked, frame_ok, frame_cnt);
    end
  endtask

  task automatic test_tall_frame;
    int nd, at;
    send_lines(V + 1, -1, 0, -1, -1, 1'b0, 24'h0);
    close_frame(nd, at);
    chk_done("tall", nd, at);
    checks++;
    if (meas_v !== 11'd25 || err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL tall_meas: v=%0d err=%0d need 25/0", meas_v, err_cnt);
    end
    checks++;
    if (frame_ok !== 1'b0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL tall_flags: ok=%b lock=%b need 0/0", frame_ok, locked);
    end
  endtask

  task automatic test_back_to_back;
    int nd, at;
    send_lines(V, -1, 0, -1, -1, 1'b0, 24'h0);
    close_frame(nd, at);
    chk_done("b2b_good", nd, at);
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL b2b_pre_lock: lock=%b need 1", locked);
    end
    close_frame(nd, at);
    chk_done("b2b_empty", nd, at);
    checks++;
    if (meas_v !== 11'd0 || meas_h !== 11'd0) begin
      errors++;
      $display("FAIL b2b_meas: h=%0d v=%0d need 0/0", meas_h, meas_v);
    end
    checks++;
    if (locked !== 1'b0 || frame_ok !== 1'b0 || frame_cnt !== 16'd7) begin
      errors++;
      $display("FAIL b2b_flags: lock=%b ok=%b cnt=%0d need 0/0/7",
               locked, frame_ok, frame_cnt);
    end
  endtask

  task automatic test_saturate;
    int nd, at;
    send_lines(1, 0, 65540, -1, -1, 1'b1, 24'h123456);
    close_frame(nd, at);
    chk_done("sat", nd, at);
    checks++;
    if (err_cnt !== 16'hFFFF || frame_ok !== 1'b0) begin
      errors++;
      $display("FAIL sat_err: err=%h ok=%b need ffff/0", err_cnt, frame_ok);
    end
    checks++;
    if (meas_h !== 11'd2047 || meas_v !== 11'd1) begin
      errors++;
      $display("FAIL sat_meas: h=%0d v=%0d need 2047/1", meas_h, meas_v);
    end
  endtask

  task automatic test_reset_midframe;
    int nd, at;
    send_lines(10, -1, 0, -1, -1, 1'b0, 24'h0);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      vif.de = 1'b1;
      {vif.R, vif.G, vif.B} = exp_rgb(10, c);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({frame_done, frame_ok, locked, err_cnt, frame_cnt, meas_h, meas_v}
        !== 57'h0) begin
      errors++;
      $display("FAIL midrst_outputs: cnt=%0d err=%0d h=%0d v=%0d need all 0",
               frame_cnt, err_cnt, meas_h, meas_v);
    end
    vif.de = 1'b0;
    {vif.R, vif.G, vif.B} = 24'h0;
    @(posedge clk); #1;
    rst = 1'b0;
    close_frame(nd, at);
    checks++;
    if (nd !== 0) begin
      errors++;
      $display("FAIL midrst_first_vs: pulses=%0d need 0", nd);
    end
    send_lines(V, -1, 0, -1, -1, 1'b0, 24'h0);
    close_frame(nd, at);
    chk_done("midrst", nd, at);
    checks++;
    if (frame_ok !== 1'b1 || frame_cnt !== 16'd1 || err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL midrst_frame: ok=%b cnt=%0d err=%0d need 1/1/0",
               frame_ok, frame_cnt, err_cnt);
    end
  endtask

  initial begin
    vif.de = 1'b0;
    vif.vsync = 1'b0;
    {vif.R, vif.G, vif.B} = 24'h0;
    test_reset;
    test_two_frames;
    test_pixel_error;
    test_short_line;
    test_tall_frame;
    test_back_to_back;
    test_saturate;
    test_reset_midframe;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
